if_df_skid_buffer: RTL and testbench



---
 rtl/if_df_skid_buffer.sv | 199 +++++++++++++++++++
 tb/tb_if_df_skid_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_df_skid_buffer.sv
// -----------------------------------------------------------------------------
// if_df_skid_buffer
//
// Fetch-to-decode pipeline buffer built as a 2-entry skid buffer. Carries the
// {pc, inst} pair from fetch to decode over a valid/ready handshake. Fetch
// sees a registered ready, so a decode stall never reaches fetch through
// combinational logic.
//
// Features beyond a plain register stage:
//   - backpressure: a skid entry absorbs the one transfer that is in flight
//     when decode stalls.
//   - flush: squashes every held entry. Any entry presented in the same
//     cycle is dropped.
//   - bubble tagging: an entry accepted with nop_in set is stored as NOP_INST
//     and flagged on nop_out.
//
// Optional build macro: IF_DF_BUF_STATS_EN
//   When defined, the block adds stall_cnt and bubble_cnt. These are
//   saturating statistics counters of width CNT_W.
// -----------------------------------------------------------------------------
module if_df_skid_buffer #(
    parameter int                 PC_W     = 16,
    parameter int                 INST_W   = 16,
    parameter logic [INST_W-1:0]  NOP_INST = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_buff_in,
    input  logic [INST_W-1:0] inst_buff_in,
    input  logic              nop_in,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_buff_out,
    output logic [INST_W-1:0] inst_buff_out,
    output logic              nop_out
`ifdef IF_DF_BUF_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // One buffered fetch result. The valid bits of the main and skid slots
    // are carried by the occupancy state below: main is valid in ONE and TWO,
    // and skid is valid only in TWO.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              nop;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam entry_t CLEAR_ENTRY = '{pc: '0, inst: NOP_INST, nop: 1'b1};

    state_t state_q, state_d;
    entry_t main_q,  main_d;
    entry_t skid_q,  skid_d;
    logic   in_ready_q, in_ready_d;

    entry_t incoming;
    logic   main_valid;
    logic   accept;
    logic   pop;

    // A bubble is stored with its PC but with the instruction forced to NOP.
    assign incoming = '{pc:   pc_buff_in,
                        inst: nop_in ? NOP_INST : inst_buff_in,
                        nop:  nop_in};

    assign main_valid = (state_q != S_EMPTY);
    assign accept     = in_valid & in_ready_q;
    assign pop        = main_valid & out_ready;

    // Occupancy register, storage slots and the registered ready flag.
    always_ff @(posedge clk) begin
        // NOTE: the data slots are reset as well as the state. Reset must leave
        // pc_buff_out at zero and inst_buff_out at NOP_INST, so the data
        // registers cannot be left unreset the way plain storage often is.
        if (rst) begin
            state_q    <= S_EMPTY;
            main_q     <= CLEAR_ENTRY;
            skid_q     <= CLEAR_ENTRY;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All
            // registers then update together from values computed before the
            // edge, and there is no ordering race between always blocks.
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic: occupancy transitions, slot loads and flush squash.
    always_comb begin
        // NOTE: every output of this block gets a default first ("hold").
        // Any path that skips an assignment then keeps the current value
        // instead of inferring a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Flush wins over accept and pop. The PC is left as it was, so
            // pc_buff_out keeps its last value while the buffer is empty.
            state_d      = S_EMPTY;
            main_d.inst  = NOP_INST;
            main_d.nop   = 1'b1;
            skid_d.inst  = NOP_INST;
            skid_d.nop   = 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        main_d  = incoming;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        main_d = incoming;
                    end else if (accept) begin
                        state_d = S_TWO;
                        skid_d  = incoming;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low in TWO, so only a pop can happen here.
                    if (pop) begin
                        state_d     = S_ONE;
                        main_d      = skid_q;
                        skid_d.inst = NOP_INST;
                        skid_d.nop  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end

        // Ready for next cycle is "skid will be free". It depends only on the
        // next state, so out_ready never reaches in_ready in the same cycle.
        in_ready_d = (state_d != S_TWO);
    end

    // Output view of the head slot. An empty buffer presents a NOP bubble.
    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid;
    assign pc_buff_out   = main_q.pc;
    assign inst_buff_out = main_valid ? main_q.inst : NOP_INST;
    assign nop_out       = main_valid ? main_q.nop  : 1'b1;

`ifdef IF_DF_BUF_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             stall_evt;
    logic             bubble_evt;

    assign stall_evt  = main_valid & ~out_ready;
    assign bubble_evt = (accept & nop_in) | flush;

    // Saturating statistics counters. Only reset clears them; flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall_evt && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (bubble_evt && !(&bubble_cnt_q)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    // The counter width only has an effect in the statistics build.
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_if_df_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_df_skid_buffer
//
// Self-checking bench for if_df_skid_buffer. A queue-based model holds at most
// two entries. Flush and reset empty it, and ready is "fewer than two held".
// The bench checks every DUT output against this model after each clock,
// through directed scenarios and then randomized traffic.
// With IF_DF_BUF_STATS_EN defined, it also checks the statistics counters.
// -----------------------------------------------------------------------------
module tb_if_df_skid_buffer;

    localparam int          PC_W     = 16;
    localparam int          INST_W   = 16;
    localparam logic [15:0] NOP_INST = 16'h0000;
    localparam int          CNT_W    = 3;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_buff_in;
    logic [INST_W-1:0] inst_buff_in;
    logic              nop_in;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_buff_out;
    logic [INST_W-1:0] inst_buff_out;
    logic              nop_out;
`ifdef IF_DF_BUF_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    if_df_skid_buffer #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pc_buff_in    (pc_buff_in),
        .inst_buff_in  (inst_buff_in),
        .nop_in        (nop_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pc_buff_out   (pc_buff_out),
        .inst_buff_out (inst_buff_out),
        .nop_out       (nop_out)
`ifdef IF_DF_BUF_STATS_EN
        ,
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an in-order queue of held entries.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
        logic        nop;
    } entry_t;

    entry_t      model_q[$];
    logic [15:0] model_last_pc;
    int          model_stall;
    int          model_bubble;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic [15:0] exp_pc;
        logic [15:0] exp_inst;
        logic        exp_nop;
        exp_pc   = model_last_pc;
        exp_inst = NOP_INST;
        exp_nop  = 1'b1;
        if (model_q.size() > 0) begin
            exp_pc   = model_q[0].pc;
            exp_inst = model_q[0].inst;
            exp_nop  = model_q[0].nop;
        end
        check("out_valid", 32'(out_valid),     32'(model_q.size() > 0));
        check("in_ready",  32'(in_ready),      32'(model_q.size() < 2));
        check("pc_out",    32'(pc_buff_out),   32'(exp_pc));
        check("inst_out",  32'(inst_buff_out), 32'(exp_inst));
        check("nop_out",   32'(nop_out),       32'(exp_nop));
`ifdef IF_DF_BUF_STATS_EN
        check("stall_cnt",  32'(stall_cnt),  32'(model_stall));
        check("bubble_cnt", 32'(bubble_cnt), 32'(model_bubble));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, clock the DUT, then
    // compare on the falling edge.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [15:0] pc, input logic [15:0] inst,
                         input logic nop, input logic ordy);
        logic   acc;
        logic   pop;
        entry_t e;
        rst          = r;
        flush        = f;
        in_valid     = iv;
        pc_buff_in   = pc;
        inst_buff_in = inst;
        nop_in       = nop;
        out_ready    = ordy;

        acc = iv && (model_q.size() < 2);
        pop = (model_q.size() > 0) && ordy;

        if (r) begin
            model_stall  = 0;
            model_bubble = 0;
        end else begin
            if ((model_q.size() > 0) && !ordy && model_stall < CNT_MAX) model_stall++;
            if (((acc && nop) || f) && model_bubble < CNT_MAX) model_bubble++;
        end

        if (r) begin
            model_q.delete();
            model_last_pc = '0;
        end else if (f) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                e.pc   = pc;
                e.inst = nop ? NOP_INST : inst;
                e.nop  = nop;
                model_q.push_back(e);
            end
        end
        if (model_q.size() > 0) model_last_pc = model_q[0].pc;

        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, ordy);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; pc_buff_in = '0;
        inst_buff_in = '0; nop_in = 1'b0; out_ready = 1'b0;
        model_last_pc = '0; model_stall = 0; model_bubble = 0;

        // Reset for two cycles.
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("rst_valid", 32'(out_valid),     32'd0);
        check("rst_ready", 32'(in_ready),      32'd1);
        check("rst_pc",    32'(pc_buff_out),   32'd0);
        check("rst_inst",  32'(inst_buff_out), 32'(NOP_INST));
        check("rst_nop",   32'(nop_out),       32'd1);

        // Streaming: each entry appears one cycle later.
        cycle(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b1);
        check("stream0", 32'(inst_buff_out), 32'h1111);
        cycle(1'b0, 1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, 1'b1);
        check("stream1", 32'(inst_buff_out), 32'h2222);
        check("stream1_rdy", 32'(in_ready), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0004, 16'h3333, 1'b0, 1'b1);
        check("stream2_pc", 32'(pc_buff_out), 32'h0004);
        idle(1'b1);
        check("stream_drained", 32'(out_valid), 32'd0);
        check("stream_pc_held", 32'(pc_buff_out), 32'h0004);

        // Backpressure: fill main and skid, then drain.
        cycle(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0022, 16'h2222, 1'b0, 1'b0);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_head", 32'(inst_buff_out), 32'h1111);
        idle(1'b1);
        check("bp_pop1", 32'(inst_buff_out), 32'h2222);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        idle(1'b1);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush while TWO, with a new entry offered in the same cycle.
        cycle(1'b0, 1'b0, 1'b1, 16'h0030, 16'h1111, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0032, 16'h2222, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 16'h0034, 16'h4444, 1'b0, 1'b1);
        check("fl_valid", 32'(out_valid),     32'd0);
        check("fl_inst",  32'(inst_buff_out), 32'h0000);
        check("fl_nop",   32'(nop_out),       32'd1);
        check("fl_ready", 32'(in_ready),      32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("fl_no4444", 32'(out_valid), 32'd0);
        end

        // Bubble entry.
        cycle(1'b0, 1'b0, 1'b1, 16'h0010, 16'hABCD, 1'b1, 1'b0);
        check("bub_pc",    32'(pc_buff_out),   32'h0010);
        check("bub_inst",  32'(inst_buff_out), 32'h0000);
        check("bub_nop",   32'(nop_out),       32'd1);
        check("bub_valid", 32'(out_valid),     32'd1);
        idle(1'b1);

        // Reset together with flush while TWO.
        cycle(1'b0, 1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0042, 16'h2222, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 16'h0044, 16'h6666, 1'b0, 1'b0);
        check("rmid_valid", 32'(out_valid),     32'd0);
        check("rmid_ready", 32'(in_ready),      32'd1);
        check("rmid_pc",    32'(pc_buff_out),   32'd0);
        check("rmid_inst",  32'(inst_buff_out), 32'(NOP_INST));
        cycle(1'b0, 1'b0, 1'b1, 16'h0050, 16'h5555, 1'b0, 1'b0);
        check("rmid_5555", 32'(inst_buff_out), 32'h5555);
        idle(1'b1);

`ifdef IF_DF_BUF_STATS_EN
        // Five stall cycles with a valid head, then one flush; then saturation.
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0060, 16'h7777, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("st_stall5",  32'(stall_cnt),  32'd5);
        check("st_bubble1", 32'(bubble_cnt), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0062, 16'h7778, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b0);
        check("st_sat", 32'(stall_cnt), 32'(CNT_MAX));
        idle(1'b1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(63) == 0),
                  ($urandom_range(15) == 0),
                  ($urandom_range(9) < 7),
                  16'($urandom),
                  16'($urandom),
                  ($urandom_range(7) == 0),
                  ($urandom_range(9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
